alu_addsub_unit: RTL and testbench

Registered WIDTH-bit adder/subtractor with an unsigned magnitude comparator, used as the add/sub/compare datapath slice of the calculator ALU. Each accepted operation computes A+B or A−B, the carry-out, and the three exclusive relation flags. All results are registered one cycle after the inputs are captured.

---
 rtl/alu_pkg.sv | 16 +
 rtl/full_adder_bit.sv | 15 +
 rtl/alu_addsub_unit.sv | 84 ++++++++
 tb/tb_alu_addsub_unit.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants and types for the calculator ALU add/sub/compare slice.
package alu_pkg;

  localparam int unsigned ALU_W = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic c_8;
    logic alb;
    logic agb;
    logic aeb;
  } alu_flags_t;

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full adder slice used to build the ripple-carry chain.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (cin & (a ^ b));
  end

endmodule

// File: rtl/alu_addsub_unit.sv
// Registered add/subtract with unsigned magnitude compare, one cycle latency.
// Define ALU_ADDSUB_OVF_EN to add the registered signed-overflow output V.
module alu_addsub_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Add_Sub,
`ifdef ALU_ADDSUB_OVF_EN
  output logic             V,
`endif
  output logic             out_valid,
  output logic [WIDTH-1:0] Sum,
  output logic             C_8,
  output logic             ALB,
  output logic             AGB,
  output logic             AEB
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] b_x;
  logic [WIDTH-1:0] sum_c;
  alu_flags_t       flags_c;

  // Subtract is A + ~B + 1: invert B and feed the op bit in as carry-in.
  always_comb begin
    b_x      = B ^ {WIDTH{Add_Sub}};
    carry[0] = (Add_Sub == OP_SUB);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_rca
    full_adder_bit u_fa (
      .a    (A[i]),
      .b    (b_x[i]),
      .cin  (carry[i]),
      .s    (sum_c[i]),
      .cout (carry[i+1])
    );
  end

  always_comb begin
    flags_c     = '0;
    flags_c.c_8 = carry[WIDTH];
    flags_c.alb = (A < B);
    flags_c.agb = (A > B);
    flags_c.aeb = (A == B);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      Sum       <= '0;
      C_8       <= 1'b0;
      ALB       <= 1'b0;
      AGB       <= 1'b0;
      AEB       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Sum <= sum_c;
        C_8 <= flags_c.c_8;
        ALB <= flags_c.alb;
        AGB <= flags_c.agb;
        AEB <= flags_c.aeb;
      end
    end
  end

`ifdef ALU_ADDSUB_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      V <= 1'b0;
    end else if (in_valid) begin
      V <= carry[WIDTH] ^ carry[WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_alu_addsub_unit.sv
// Self-checking bench for alu_addsub_unit against an arithmetic reference model.
module tb_alu_addsub_unit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Add_Sub;
  logic         out_valid;
  logic [W-1:0] Sum;
  logic         C_8, ALB, AGB, AEB;
`ifdef ALU_ADDSUB_OVF_EN
  logic         V;
`endif

  int total = 0;
  int bad   = 0;

  logic         m_valid, m_c, m_lt, m_gt, m_eq, m_v;
  logic [W-1:0] m_sum;

  always #5 clk = ~clk;

  alu_addsub_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .Add_Sub   (Add_Sub),
`ifdef ALU_ADDSUB_OVF_EN
    .V         (V),
`endif
    .out_valid (out_valid),
    .Sum       (Sum),
    .C_8       (C_8),
    .ALB       (ALB),
    .AGB       (AGB),
    .AEB       (AEB)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the sampled operands.
  task automatic model(input logic r, input logic iv, input int a, input int b, input logic sub);
    int full, sa, sb, sres;
    if (r) begin
      m_valid = 0; m_sum = '0; m_c = 0; m_lt = 0; m_gt = 0; m_eq = 0; m_v = 0;
    end else begin
      m_valid = iv;
      if (iv) begin
        full  = sub ? (a - b + (1 << W)) : (a + b);
        m_sum = W'(full % (1 << W));
        m_c   = sub ? (a >= b) : (a + b >= (1 << W));
        m_lt  = a < b;
        m_gt  = a > b;
        m_eq  = a == b;
        sa    = (a >= (1 << (W-1))) ? a - (1 << W) : a;
        sb    = (b >= (1 << (W-1))) ? b - (1 << W) : b;
        sres  = sub ? sa - sb : sa + sb;
        m_v   = (sres > (1 << (W-1)) - 1) || (sres < -(1 << (W-1)));
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, ".Sum"}, 32'(Sum), 32'(m_sum));
    chk({tag, ".C_8"}, 32'(C_8), 32'(m_c));
    chk({tag, ".flags"}, 32'({ALB, AGB, AEB}), 32'({m_lt, m_gt, m_eq}));
`ifdef ALU_ADDSUB_OVF_EN
    chk({tag, ".V"}, 32'(V), 32'(m_v));
`endif
  endtask

  task automatic step(input string tag, input logic r, input logic iv,
                      input int a, input int b, input logic sub);
    @(negedge clk);
    rst = r; in_valid = iv; A = W'(a); B = W'(b); Add_Sub = sub;
    @(posedge clk);
    model(r, iv, a, b, sub);
    #1;
    check_all(tag);
  endtask

  task automatic exp_const(input string tag, input int s, input logic c,
                           input logic [2:0] f);
    chk({tag, ".dirSum"}, 32'(Sum), 32'(s));
    chk({tag, ".dirC"}, 32'(C_8), 32'(c));
    chk({tag, ".dirFlags"}, 32'({ALB, AGB, AEB}), 32'(f));
  endtask

  initial begin
    rst = 1; in_valid = 1; A = 8'h55; B = 8'h11; Add_Sub = 0;
    step("rst0", 1, 1, 8'h55, 8'h11, 0);
    step("rst1", 1, 1, 8'h55, 8'h11, 0);
    chk("rst.dirValid", 32'(out_valid), 0);
    exp_const("rst", 0, 0, 3'b000);

    step("add_gt", 0, 1, 8'h3F, 8'h3E, 0); exp_const("add_gt", 8'h7D, 0, 3'b010);
    step("sub_gt", 0, 1, 8'h3F, 8'h3E, 1); exp_const("sub_gt", 8'h01, 1, 3'b010);
    step("add_eq", 0, 1, 8'h3F, 8'h3F, 0); exp_const("add_eq", 8'h7E, 0, 3'b001);
    step("sub_eq", 0, 1, 8'h3F, 8'h3F, 1); exp_const("sub_eq", 8'h00, 1, 3'b001);
    step("add_lt", 0, 1, 8'h3F, 8'h40, 0); exp_const("add_lt", 8'h7F, 0, 3'b100);
    step("sub_lt", 0, 1, 8'h3F, 8'h40, 1); exp_const("sub_lt", 8'hFF, 0, 3'b100);
    step("add_ovf", 0, 1, 8'h3F, 8'h41, 0); exp_const("add_ovf", 8'h80, 0, 3'b100);
`ifdef ALU_ADDSUB_OVF_EN
    chk("add_ovf.dirV", 32'(V), 1);
`endif
    step("add_wrap", 0, 1, 8'hFF, 8'h02, 0); exp_const("add_wrap", 8'h01, 1, 3'b010);
`ifdef ALU_ADDSUB_OVF_EN
    chk("add_wrap.dirV", 32'(V), 0);
`endif

    step("tog1", 0, 1, 8'h10, 8'h20, 1);
    step("tog0", 0, 0, 8'hAA, 8'h05, 0);
    exp_const("tog0.hold", 8'hF0, 0, 3'b100);
    chk("tog0.dirValid", 32'(out_valid), 0);
    step("tog1b", 0, 1, 8'h80, 8'h80, 0);
    step("midrst", 1, 1, 8'h12, 8'h34, 0);
    exp_const("midrst", 0, 0, 3'b000);

    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, (1 << W) - 1)),
           $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
